// File: rtl/aes_pkg.sv
// Shared AES constants and word helpers used by the key-schedule block.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    EMIT
  } ks_state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Indexed directly by i/Nk; entry 0 and the tail are padding so any 4-bit index is in range.
  localparam logic [7:0] RCON [16] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {SBOX[x[31:24]], SBOX[x[23:16]], SBOX[x[15:8]], SBOX[x[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_sched_rev.sv
// Iterative AES key expansion (one word per cycle) that replays round keys
// last-to-first for an inverse cipher, over a valid/ready stream.
module aes_key_sched_rev
  import aes_pkg::*;
#(
  parameter int Nk = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [32*Nk-1:0]  key,
  output logic              busy,
  output logic              rk_valid,
  input  logic              rk_ready,
  output logic [127:0]      rk,
  output logic [3:0]        rk_idx,
  output logic              rk_last
);

  localparam int Nr = Nk + 6;
  localparam int Nw = 4 * (Nr + 1);

  localparam logic [5:0] NK_W    = 6'(Nk);
  localparam logic [5:0] LAST_W  = 6'(Nw - 1);
  localparam logic [2:0] MOD_MAX = 3'(Nk - 1);
  localparam logic [3:0] NR_R    = 4'(Nr);

  ks_state_e   state_q, state_d;
  logic [5:0]  i_q, i_d;
  logic [2:0]  imod_q, imod_d;
  logic [3:0]  idiv_q, idiv_d;
  logic [3:0]  r_q, r_d;
  logic        key_we, exp_we;

  logic [31:0] w_q [Nw];
  logic [31:0] w_prev, w_back, t_word, w_new;
  logic [5:0]  rk_base;

  // Next schedule word from w[i-1] and w[i-Nk]; i%Nk and i/Nk come from counters.
  always_comb begin
    w_prev = w_q[i_q - 6'd1];
    w_back = w_q[i_q - NK_W];
    t_word = w_prev;
    if (imod_q == 3'd0) begin
      t_word = sub_word(rot_word(w_prev)) ^ {RCON[idiv_q], 24'h000000};
    end else if (Nk == 8 && imod_q == 3'd4) begin
      t_word = sub_word(w_prev);
    end
    w_new = w_back ^ t_word;
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    imod_d  = imod_q;
    idiv_d  = idiv_q;
    r_d     = r_q;
    key_we  = 1'b0;
    exp_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          key_we  = 1'b1;
          i_d     = NK_W;
          imod_d  = 3'd0;
          idiv_d  = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        exp_we = 1'b1;
        i_d    = i_q + 6'd1;
        if (imod_q == MOD_MAX) begin
          imod_d = 3'd0;
          idiv_d = idiv_q + 4'd1;
        end else begin
          imod_d = imod_q + 3'd1;
        end
        if (i_q == LAST_W) begin
          r_d     = NR_R;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (rk_ready) begin
          if (r_q == 4'd0) state_d = IDLE;
          else             r_d     = r_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      imod_q  <= '0;
      idiv_q  <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      imod_q  <= imod_d;
      idiv_q  <= idiv_d;
      r_q     <= r_d;
    end
  end

  // Round-key buffer carries data only; stale contents are never visible because rk is gated by rk_valid.
  always_ff @(posedge clk) begin
    if (key_we) begin
      for (int j = 0; j < Nk; j++) w_q[j] <= key[32*Nk-1-32*j -: 32];
    end else if (exp_we) begin
      w_q[i_q] <= w_new;
    end
  end

  assign rk_base  = {r_q, 2'b00};
  assign busy     = (state_q != IDLE);
  assign rk_valid = (state_q == EMIT);
  assign rk_idx   = rk_valid ? r_q : 4'd0;
  assign rk_last  = rk_valid && (r_q == 4'd0);
  assign rk       = rk_valid ? {w_q[rk_base], w_q[rk_base + 6'd1],
                                w_q[rk_base + 6'd2], w_q[rk_base + 6'd3]} : 128'd0;

endmodule
